// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: fetch FSM encoding, reset vector default, opcode
// constants and program-counter helpers.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_FULL  = 2'b10,
        ST_DRAIN = 2'b11
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

    // Addition wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return align_pc(pc + 32'd4);
    endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer that catches a
// memory response arriving while decode is stalled.
module if_id_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        skid_load,
    input  logic        skid_move,
    input  logic        consume,
    input  logic [31:0] rdata,
    input  logic [31:0] pc4,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
);

    logic        valid_q, valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    // Next-state selection for the IF/ID slot and the skid entry; flush wins.
    always_comb begin
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        if (flush) begin
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_move && skid_valid_q) begin
            instr_d      = skid_instr_q;
            pc4_d        = skid_pc4_q;
            valid_d      = 1'b1;
            skid_valid_d = 1'b0;
        end else if (load) begin
            instr_d = rdata;
            pc4_d   = pc4;
            valid_d = 1'b1;
        end else if (skid_load) begin
            skid_instr_d = rdata;
            skid_pc4_d   = pc4;
            skid_valid_d = 1'b1;
        end else if (consume) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Register bank for IF/ID and skid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            instr_q      <= 32'h0000_0000;
            pc4_q        <= 32'h0000_0000;
            skid_valid_q <= 1'b0;
            skid_instr_q <= 32'h0000_0000;
            skid_pc4_q   <= 32'h0000_0000;
        end else begin
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign if_valid = valid_q;
    assign if_instr = instr_q;
    assign if_pc4   = pc4_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: request FSM and program counter, feeding the IF/ID
// register. Redirects flush everything and discard an in-flight response.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    output logic [5:0]  opcode
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         imem_req_q;
    logic         load_s, skid_load_s, skid_move_s, flush_s, slot_free_s;
    logic [31:0]  pc_plus4_s;

    assign pc_plus4_s  = next_pc(pc_q);
    assign slot_free_s = id_ready || !if_valid;

    // Next-state, pc update and IF/ID control strobes.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        load_s      = 1'b0;
        skid_load_s = 1'b0;
        skid_move_s = 1'b0;
        flush_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
                if (redirect) begin
                    flush_s = 1'b1;
                    pc_d    = align_pc(redirect_target);
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FETCH: begin
                if (redirect) begin
                    flush_s = 1'b1;
                    pc_d    = align_pc(redirect_target);
                    state_d = imem_valid ? ST_FETCH : ST_DRAIN;
                end else if (imem_valid && slot_free_s) begin
                    load_s = 1'b1;
                    pc_d   = pc_plus4_s;
                end else if (imem_valid) begin
                    skid_load_s = 1'b1;
                    state_d     = ST_FULL;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_FULL: begin
                if (redirect) begin
                    flush_s = 1'b1;
                    pc_d    = align_pc(redirect_target);
                    state_d = ST_FETCH;
                end else if (id_ready) begin
                    skid_move_s = 1'b1;
                    pc_d        = pc_plus4_s;
                    state_d     = ST_FETCH;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_DRAIN: begin
                // A response landing with the redirect still closes the drain.
                if (redirect) begin
                    flush_s = 1'b1;
                    pc_d    = align_pc(redirect_target);
                    state_d = imem_valid ? ST_FETCH : ST_DRAIN;
                end else if (imem_valid) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, program counter and registered request strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= align_pc(RESET_PC);
            imem_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= align_pc(pc_d);
            imem_req_q <= (state_d == ST_FETCH);
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_s),
        .load      (load_s),
        .skid_load (skid_load_s),
        .skid_move (skid_move_s),
        .consume   (id_ready),
        .rdata     (imem_rdata),
        .pc4       (pc_plus4_s),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_pc4    (if_pc4)
    );

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign opcode    = if_instr[31:26];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model and a
// scoreboard of delivered instructions checked as decode consumes them.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic [5:0]  opcode;

    logic        w_rst_n, w_req, w_valid, w_id_ready, w_redirect, w_if_valid;
    logic [31:0] w_addr, w_rdata, w_target, w_if_instr, w_if_pc4;
    logic [5:0]  w_opcode;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_pops  = 0;
    logic [63:0] sb_q[$];
    logic [31:0] req_log[$];
    bit          out_v;
    bit          killed;
    logic [31:0] out_addr;
    int          cnt;
    int          lat;
    logic [31:0] exp_w;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .id_ready(id_ready),
        .redirect(redirect), .redirect_target(redirect_target), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc4(if_pc4), .opcode(opcode)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata), .id_ready(w_id_ready),
        .redirect(w_redirect), .redirect_target(w_target), .if_valid(w_if_valid),
        .if_instr(w_if_instr), .if_pc4(w_if_pc4), .opcode(w_opcode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:2] ^ 6'h15, 10'h2AA, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score the edge about to happen, then advance the memory model.
    task automatic tick();
        logic [63:0] e;
        if (rst_n) begin
            if (redirect) begin
                sb_q.delete();
                killed = 1'b1;
            end else begin
                if (if_valid && id_ready) begin
                    n_pops++;
                    n_tests++;
                    assert (sb_q.size() != 0) else begin
                        n_fail++;
                        $error("FAIL sb_empty observed=%0d expected=nonzero", sb_q.size());
                    end
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        chk("sb_instr", if_instr, e[63:32]);
                        chk("sb_pc4", if_pc4, e[31:0]);
                        chk("sb_opcode", {26'd0, opcode}, {26'd0, e[63:58]});
                    end
                end
                if (imem_valid && !killed)
                    sb_q.push_back({mem_word(out_addr), out_addr + 32'd4});
            end
        end
        @(posedge clk);
        #1;
        if (!rst_n) begin
            out_v = 1'b0;
            imem_valid = 1'b0;
            sb_q.delete();
        end else begin
            if (imem_valid) begin
                imem_valid = 1'b0;
                out_v = 1'b0;
            end
            if (out_v) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(out_addr);
                end
            end else if (imem_req) begin
                out_v = 1'b1;
                out_addr = imem_addr;
                cnt = lat;
                killed = 1'b0;
                req_log.push_back(imem_addr);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; w_rst_n = 1'b0; id_ready = 1'b1; redirect = 1'b0;
        redirect_target = 32'h0; imem_valid = 1'b0; imem_rdata = 32'h0; lat = 1;
        w_valid = 1'b0; w_rdata = 32'h0; w_id_ready = 1'b1; w_redirect = 1'b0;
        w_target = 32'h0; out_v = 1'b0; killed = 1'b0; out_addr = 32'h0; cnt = 0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_ifv", {31'd0, if_valid}, 32'd0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_pc4", if_pc4, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);

        // Streaming with latency 1 and decode always ready.
        rst_n = 1'b1;
        tick();
        chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_ifv", {31'd0, if_valid}, 32'd0);
        tick();
        chk("c2_ifv", {31'd0, if_valid}, 32'd0);
        tick();
        exp_w = mem_word(32'h0);
        chk("c3_ifv", {31'd0, if_valid}, 32'd1);
        chk("c3_addr", imem_addr, 32'h4);
        chk("c3_opcode", {26'd0, opcode}, {26'd0, exp_w[31:26]});
        tick();
        chk("c4_ifv_clear", {31'd0, if_valid}, 32'd0);

        // Decode stall while the response for address 8 returns.
        tick();
        id_ready = 1'b0;
        tick(); tick();
        exp_w = mem_word(32'h4);
        chk("full_req", {31'd0, imem_req}, 32'd0);
        chk("full_hold", if_instr, exp_w);
        tick();
        chk("full_req2", {31'd0, imem_req}, 32'd0);
        id_ready = 1'b1;
        lat = 3;
        tick();
        chk("skid_ifv", {31'd0, if_valid}, 32'd1);
        chk("skid_instr", if_instr, mem_word(32'h8));
        chk("skid_pc4", if_pc4, 32'hC);
        chk("skid_req", {31'd0, imem_req}, 32'd1);
        chk("skid_addr", imem_addr, 32'hC);
        chk("log_size", req_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < req_log.size(); i++)
            chk("log_addr", req_log[i], 32'(i * 4));

        // Redirect while the latency-3 request at 12 is outstanding.
        tick();
        chk("c10_ifv", {31'd0, if_valid}, 32'd0);
        redirect = 1'b1; redirect_target = 32'h40;
        tick();
        redirect = 1'b0;
        chk("drain_req", {31'd0, imem_req}, 32'd0);
        chk("drain_ifv", {31'd0, if_valid}, 32'd0);
        chk("drain_pc", imem_addr, 32'h40);
        tick();
        chk("drain_ifv2", {31'd0, if_valid}, 32'd0);
        tick();
        chk("tgt_req", {31'd0, imem_req}, 32'd1);
        chk("tgt_addr", imem_addr, 32'h40);
        chk("tgt_ifv", {31'd0, if_valid}, 32'd0);

        // Redirect in the same cycle as the response: no drain.
        tick(); tick(); tick();
        redirect = 1'b1; redirect_target = 32'h80; lat = 1;
        tick();
        redirect = 1'b0;
        chk("co_req", {31'd0, imem_req}, 32'd1);
        chk("co_addr", imem_addr, 32'h80);
        chk("co_ifv", {31'd0, if_valid}, 32'd0);
        tick(); tick();
        chk("co_instr", if_instr, mem_word(32'h80));
        chk("co_pc4", if_pc4, 32'h84);
        tick(); tick();
        chk("pre_rst_ifv", {31'd0, if_valid}, 32'd1);
        chk("pre_rst_req", {31'd0, imem_req}, 32'd1);

        // Asynchronous reset with a request outstanding.
        rst_n = 1'b0;
        #1;
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        chk("ar_ifv", {31'd0, if_valid}, 32'd0);
        chk("ar_instr", if_instr, 32'h0);
        chk("ar_pc4", if_pc4, 32'h0);
        chk("ar_addr", imem_addr, 32'h0);
        out_v = 1'b0; imem_valid = 1'b0; sb_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_req", {31'd0, imem_req}, 32'd1);
        chk("rs_addr", imem_addr, 32'h0);
        tick(); tick();
        chk("rs_ifv", {31'd0, if_valid}, 32'd1);
        chk("rs_instr", if_instr, mem_word(32'h0));
        chk("rs_pc4", if_pc4, 32'h4);
        tick();
        chk("pop_count", n_pops, 32'd5);
        chk("sb_drained", sb_q.size(), 32'd0);

        // Reset vector at the top of the address space wraps to zero.
        w_rst_n = 1'b1;
        @(posedge clk); #1;
        chk("w_req", {31'd0, w_req}, 32'd1);
        chk("w_addr0", w_addr, 32'hFFFF_FFFC);
        w_valid = 1'b1; w_rdata = {OP_LW, 26'h001_0004};
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk("w_ifv", {31'd0, w_if_valid}, 32'd1);
        chk("w_pc4", w_if_pc4, 32'h0);
        chk("w_addr1", w_addr, 32'h0);
        chk("w_instr", w_if_instr, {OP_LW, 26'h001_0004});
        chk("w_opcode", {26'd0, w_opcode}, {26'd0, OP_LW});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
